// File: rtl/vreg_operand_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : vreg_operand_collector_if
// Brief    : Request, bank-return and execute-side bundle of the collector.
// Revision : 1.0
// ============================================================================
interface vreg_operand_collector_if #(
    parameter int READ_PORTS = 4,
    parameter int DATA_W     = 512,
    parameter int VLMAX      = 32
) ();
    logic                         req_valid;
    logic                         req_ready;
    logic [READ_PORTS-1:0]        req_pmask;
    logic                         req_mexp;
    logic [READ_PORTS-1:0]        rd_valid;
    logic [READ_PORTS*DATA_W-1:0] rd_data;
    logic                         mrd_valid;
    logic [VLMAX-1:0]             mrd_data;
    logic                         flush;
    logic                         ivalid;
    logic                         iready;
    logic [READ_PORTS*DATA_W-1:0] op_vreg;
    logic [VLMAX-1:0]             op_mask;
    logic                         timeout_err;

    modport slave (
        input  req_valid, req_pmask, req_mexp, rd_valid, rd_data,
               mrd_valid, mrd_data, flush, iready,
        output req_ready, ivalid, op_vreg, op_mask, timeout_err
    );

    modport master (
        output req_valid, req_pmask, req_mexp, rd_valid, rd_data,
               mrd_valid, mrd_data, flush, iready,
        input  req_ready, ivalid, op_vreg, op_mask, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/vreg_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : vreg_operand_collector
// Brief    : Gathers one instruction's operands and mask from bank returns and
//            queues complete groups for execute. OPC_TIMEOUT_EN adds watchdog.
// Revision : 1.0
// ============================================================================
module vreg_operand_collector #(
    parameter int READ_PORTS = 4,
    parameter int DATA_W     = 512,
    parameter int VLMAX      = 32,
    parameter int DEPTH      = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic                       CLK,
    input  logic                       nRST,
    vreg_operand_collector_if.slave    bus
);
    localparam int c_GRP_W = READ_PORTS * DATA_W;
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [READ_PORTS-1:0] r_pmask_q, w_pmask_d;
    logic                  r_mexp_q, w_mexp_d;
    logic [READ_PORTS-1:0] r_got_q, w_got_d;
    logic                  r_got_m_q, w_got_m_d;
    logic [c_GRP_W-1:0]    r_data_q, w_data_d;
    logic [VLMAX-1:0]      r_mask_q, w_mask_d;
    logic [c_GRP_W-1:0]    r_mem_vreg_q [DEPTH];
    logic [c_GRP_W-1:0]    w_mem_vreg_d [DEPTH];
    logic [VLMAX-1:0]      r_mem_mask_q [DEPTH];
    logic [VLMAX-1:0]      w_mem_mask_d [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]    r_count_q, w_count_d;

    logic                  w_ivalid;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_collect;
    logic [READ_PORTS-1:0] w_ret;
    logic                  w_ret_m;
    logic                  w_done;
    logic                  w_expire;
    logic                  w_push;
    logic [c_GRP_W-1:0]    w_push_vreg;
    logic [VLMAX-1:0]      w_push_mask;

    assign w_ivalid  = (r_count_q != '0);
    assign w_pop     = w_ivalid && bus.iready;
    // A slot freed by this cycle's pop is usable by this cycle's push.
    assign w_full    = (r_count_q == c_CNT_W'(DEPTH)) && !w_pop;
    assign w_collect = (r_state_q == S_COLLECT);
    assign w_ret     = w_collect ? (bus.rd_valid & r_pmask_q) : '0;
    assign w_ret_m   = w_collect && bus.mrd_valid && r_mexp_q;

`ifdef OPC_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);
    logic [c_TMO_W-1:0] r_tmo_cnt_q, w_tmo_cnt_d;
    logic               r_tmo_err_q, w_tmo_err_d;

    // Counter only advances while waiting in COLLECT with no accepted return.
    assign w_expire    = w_collect && (w_ret == '0) && !w_ret_m &&
                         (r_tmo_cnt_q == c_TMO_W'(TIMEOUT - 1));
    assign w_tmo_cnt_d = (!w_collect || (w_ret != '0) || w_ret_m) ? '0
                                                                  : r_tmo_cnt_q + 1'b1;
    assign w_tmo_err_d = r_tmo_err_q || w_expire;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_tmo_cnt_q <= '0;
            r_tmo_err_q <= 1'b0;
        end else begin
            r_tmo_cnt_q <= w_tmo_cnt_d;
            r_tmo_err_q <= w_tmo_err_d;
        end
    end

    assign bus.timeout_err = r_tmo_err_q;
`else
    assign w_expire        = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        w_state_d   = r_state_q;
        w_pmask_d   = r_pmask_q;
        w_mexp_d    = r_mexp_q;
        w_got_d     = r_got_q | w_ret;
        w_got_m_d   = r_got_m_q | w_ret_m;
        w_data_d    = r_data_q;
        w_mask_d    = r_mask_q;
        w_push      = 1'b0;
        w_push_vreg = '0;
        w_push_mask = '0;
        w_done      = 1'b0;

        for (int i = 0; i < READ_PORTS; i++) begin
            if (w_ret[i]) begin
                w_data_d[i*DATA_W +: DATA_W] = bus.rd_data[i*DATA_W +: DATA_W];
            end
        end
        if (w_ret_m) begin
            w_mask_d = bus.mrd_data;
        end

        case (r_state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_pmask_d = bus.req_pmask;
                    w_mexp_d  = bus.req_mexp;
                    w_got_d   = '0;
                    w_got_m_d = 1'b0;
                    w_data_d  = '0;
                    w_mask_d  = '0;
                    if ((bus.req_pmask == '0) && !bus.req_mexp) begin
                        if (!w_full) begin
                            w_push = 1'b1;
                        end else begin
                            w_state_d = S_HOLD;
                        end
                    end else begin
                        w_state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                w_done = (&(w_got_d | ~r_pmask_q)) && (w_got_m_d || !r_mexp_q);
                if (w_done || w_expire) begin
                    if (!w_full) begin
                        w_push      = 1'b1;
                        w_push_vreg = w_data_d;
                        w_push_mask = w_mask_d;
                        w_state_d   = S_IDLE;
                    end else begin
                        w_state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_push_vreg = r_data_q;
                    w_push_mask = r_mask_q;
                    w_state_d   = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        if (bus.flush) begin
            w_state_d = S_IDLE;
            w_got_d   = '0;
            w_got_m_d = 1'b0;
            w_push    = 1'b0;
        end
    end

    always_comb begin
        w_mem_vreg_d = r_mem_vreg_q;
        w_mem_mask_d = r_mem_mask_q;
        w_wr_ptr_d   = r_wr_ptr_q;
        w_rd_ptr_d   = r_rd_ptr_q;
        w_count_d    = r_count_q;
        if (w_push) begin
            w_mem_vreg_d[r_wr_ptr_q] = w_push_vreg;
            w_mem_mask_d[r_wr_ptr_q] = w_push_mask;
            w_wr_ptr_d               = r_wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + 1'b1;
            2'b01:   w_count_d = r_count_q - 1'b1;
            default: w_count_d = r_count_q;
        endcase
        if (bus.flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state_q  <= S_IDLE;
            r_pmask_q  <= '0;
            r_mexp_q   <= 1'b0;
            r_got_q    <= '0;
            r_got_m_q  <= 1'b0;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pmask_q  <= w_pmask_d;
            r_mexp_q   <= w_mexp_d;
            r_got_q    <= w_got_d;
            r_got_m_q  <= w_got_m_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
        end
    end

    // Payload storage is cleared on group accept and masked when empty, so it needs no reset.
    always_ff @(posedge CLK) begin
        r_data_q     <= w_data_d;
        r_mask_q     <= w_mask_d;
        r_mem_vreg_q <= w_mem_vreg_d;
        r_mem_mask_q <= w_mem_mask_d;
    end

    assign bus.req_ready = nRST && (r_state_q == S_IDLE);
    assign bus.ivalid    = w_ivalid;
    assign bus.op_vreg   = w_ivalid ? r_mem_vreg_q[r_rd_ptr_q] : '0;
    assign bus.op_mask   = w_ivalid ? r_mem_mask_q[r_rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: tb/tb_vreg_operand_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_vreg_operand_collector
// Brief    : Directed self-checking bench for vreg_operand_collector.
// Revision : 1.0
// ============================================================================
module tb_vreg_operand_collector;
    localparam int READ_PORTS = 4;
    localparam int DATA_W     = 512;
    localparam int VLMAX      = 32;
    localparam int DEPTH      = 2;
    localparam int TIMEOUT    = 64;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_errors;

    vreg_operand_collector_if #(
        .READ_PORTS (READ_PORTS),
        .DATA_W     (DATA_W),
        .VLMAX      (VLMAX)
    ) bus ();

    vreg_operand_collector #(
        .READ_PORTS (READ_PORTS),
        .DATA_W     (DATA_W),
        .VLMAX      (VLMAX),
        .DEPTH      (DEPTH),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pdat(input int g, input int p);
        logic [31:0] w;
        w = {8'hA5, 8'(g), 8'(p), 8'h3C};
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rets();
        bus.rd_valid  = '0;
        bus.mrd_valid = 1'b0;
    endtask

    task automatic drive_ret(input int g, input logic [READ_PORTS-1:0] v);
        bus.rd_valid = v;
        for (int p = 0; p < READ_PORTS; p++) begin
            bus.rd_data[p*DATA_W +: DATA_W] = pdat(g, p);
        end
    endtask

    task automatic request(input logic [READ_PORTS-1:0] pm, input logic me);
        bus.req_valid = 1'b1;
        bus.req_pmask = pm;
        bus.req_mexp  = me;
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic check_head(input string tag, input int g, input logic [READ_PORTS-1:0] pm,
                              input logic [VLMAX-1:0] m);
        check({tag, ".ivalid"}, DATA_W'(bus.ivalid), DATA_W'(1));
        for (int p = 0; p < READ_PORTS; p++) begin
            check($sformatf("%s.port%0d", tag, p), bus.op_vreg[p*DATA_W +: DATA_W],
                  pm[p] ? pdat(g, p) : '0);
        end
        check({tag, ".mask"}, DATA_W'(bus.op_mask), DATA_W'(m));
    endtask

    task automatic issue_full(input int g, input logic [VLMAX-1:0] m);
        request(4'b1111, 1'b1);
        drive_ret(g, 4'b1111);
        bus.mrd_valid = 1'b1;
        bus.mrd_data  = m;
        tick();
        clear_rets();
    endtask

    initial begin
        int n;
        n_checks      = 0;
        n_errors      = 0;
        nrst          = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_pmask = '0;
        bus.req_mexp  = 1'b0;
        bus.rd_valid  = '0;
        bus.rd_data   = '0;
        bus.mrd_valid = 1'b0;
        bus.mrd_data  = '0;
        bus.flush     = 1'b0;
        bus.iready    = 1'b0;
        tick();
        tick();

        check("rst.req_ready", DATA_W'(bus.req_ready), '0);
        check("rst.ivalid", DATA_W'(bus.ivalid), '0);
        check("rst.op_vreg0", bus.op_vreg[DATA_W-1:0], '0);
        check("rst.op_mask", DATA_W'(bus.op_mask), '0);
        check("rst.timeout_err", DATA_W'(bus.timeout_err), '0);
        nrst = 1'b1;
        #1;
        check("idle.req_ready", DATA_W'(bus.req_ready), DATA_W'(1));

        // T1: every operand and the mask arrive together
        bus.iready = 1'b1;
        request(4'b1111, 1'b1);
        check("t1.collect_ready", DATA_W'(bus.req_ready), '0);
        drive_ret(1, 4'b1111);
        bus.mrd_valid = 1'b1;
        bus.mrd_data  = 32'hFFFF_FFFF;
        #1;
        check("t1.early_ivalid", DATA_W'(bus.ivalid), '0);
        tick();
        clear_rets();
        check_head("t1", 1, 4'b1111, 32'hFFFF_FFFF);
        tick();
        check("t1.drained", DATA_W'(bus.ivalid), '0);

        // T2: bank conflicts spread the returns over four cycles
        request(4'b1111, 1'b1);
        drive_ret(2, 4'b0011);
        tick();
        clear_rets();
        bus.mrd_valid = 1'b1;
        bus.mrd_data  = 32'h1234_5678;
        tick();
        clear_rets();
        tick();
        check("t2.partial_ivalid", DATA_W'(bus.ivalid), '0);
        check("t2.partial_ready", DATA_W'(bus.req_ready), '0);
        drive_ret(2, 4'b1100);
        tick();
        clear_rets();
        check_head("t2", 2, 4'b1111, 32'h1234_5678);
        tick();
        check("t2.drained", DATA_W'(bus.ivalid), '0);

        // T3: three groups against a stalled two-entry FIFO
        bus.iready = 1'b0;
        issue_full(3, 32'h0303_0303);
        issue_full(4, 32'h0404_0404);
        issue_full(5, 32'h0505_0505);
        check("t3.hold_ready", DATA_W'(bus.req_ready), '0);
        tick();
        check_head("t3.stall_a", 3, 4'b1111, 32'h0303_0303);
        bus.iready = 1'b1;
        tick();
        check_head("t3.b", 4, 4'b1111, 32'h0404_0404);
        check("t3.idle_ready", DATA_W'(bus.req_ready), DATA_W'(1));
        tick();
        check_head("t3.c", 5, 4'b1111, 32'h0505_0505);
        tick();
        check("t3.drained", DATA_W'(bus.ivalid), '0);

        // T4: return on a port the group does not expect
        request(4'b0011, 1'b0);
        drive_ret(6, 4'b1011);
        bus.mrd_valid = 1'b1;
        bus.mrd_data  = 32'hDEAD_BEEF;
        tick();
        clear_rets();
        check_head("t4", 6, 4'b0011, 32'h0);
        tick();

        // Empty group goes straight to the FIFO as zeros
        request(4'b0000, 1'b0);
        check_head("empty", 0, 4'b0000, 32'h0);
        check("empty.ready", DATA_W'(bus.req_ready), DATA_W'(1));
        tick();
        check("empty.drained", DATA_W'(bus.ivalid), '0);

        // T5: flush with one queued group and one half-collected
        bus.iready = 1'b0;
        issue_full(7, 32'h0707_0707);
        request(4'b1111, 1'b1);
        drive_ret(8, 4'b0001);
        tick();
        bus.flush = 1'b1;
        drive_ret(8, 4'b1110);
        bus.mrd_valid = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t5.ivalid", DATA_W'(bus.ivalid), '0);
        check("t5.ready", DATA_W'(bus.req_ready), DATA_W'(1));
        tick();
        clear_rets();
        check("t5.late_ivalid", DATA_W'(bus.ivalid), '0);
        check("t5.late_ready", DATA_W'(bus.req_ready), DATA_W'(1));

        // Reset in the middle of collection discards the group
        bus.iready = 1'b1;
        request(4'b1111, 1'b1);
        drive_ret(9, 4'b0011);
        tick();
        clear_rets();
        nrst = 1'b0;
        tick();
        check("rst2.ready", DATA_W'(bus.req_ready), '0);
        check("rst2.ivalid", DATA_W'(bus.ivalid), '0);
        nrst = 1'b1;
        drive_ret(9, 4'b1100);
        bus.mrd_valid = 1'b1;
        tick();
        clear_rets();
        check("rst2.ignored", DATA_W'(bus.ivalid), '0);
        check("rst2.idle", DATA_W'(bus.req_ready), DATA_W'(1));

`ifdef OPC_TIMEOUT_EN
        // T6: port 2 never returns
        request(4'b1111, 1'b1);
        drive_ret(10, 4'b1011);
        bus.mrd_valid = 1'b1;
        bus.mrd_data  = 32'hCAFE_F00D;
        tick();
        clear_rets();
        n = 0;
        while (!bus.timeout_err && n < 200) begin
            tick();
            n++;
        end
        check("t6.cycles", DATA_W'(n), DATA_W'(TIMEOUT));
        check_head("t6", 10, 4'b1011, 32'hCAFE_F00D);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("t6.sticky", DATA_W'(bus.timeout_err), DATA_W'(1));
`else
        n = 0;
        check("no_tmo.err", DATA_W'(bus.timeout_err), DATA_W'(n));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
